// File: rtl/safe_lock_pkg.sv
// Shared definitions for the safe-lock serial key link (transmitter and receiver).
package safe_lock_pkg;

    localparam int unsigned KEY_W = 4;

    typedef logic [KEY_W-1:0] key_t;

    // Bits travel MSB first on the serial link.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: MSB-first bits in, N-bit words out through a holding register.
module s2p
    import safe_lock_pkg::*;
#(
    parameter int unsigned N = KEY_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ser_data,
    input  logic         ser_valid,
    output logic         ser_ready,
    input  logic         ser_clear,
    output logic [N-1:0] par_data,
    output logic         par_valid,
    input  logic         par_ready
);

    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    // Only the N-1 most recent bits are ever needed; the Nth arrives with the completing beat.
    logic [N-2:0]    shreg;
    logic [CntW-1:0] cnt;
    logic [N-1:0]    word;
    logic            last;
    logic            beat;

    assign last = (cnt == CntLast);
    assign word = {shreg, ser_data};

    // Combinational par_ready -> ser_ready path: the last bit may land while the holder drains.
    assign ser_ready = !(last && par_valid && !par_ready);
    assign beat      = ser_valid && ser_ready && !ser_clear;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg     <= '0;
            cnt       <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
        end else begin
            if (ser_clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (beat) begin
                shreg <= word[N-2:0];
                cnt   <= last ? '0 : cnt + CntW'(1);
            end

            if (beat && last) begin
                par_data  <= word;
                par_valid <= 1'b1;
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p.sv
// Directed self-checking bench for s2p (N = 4).
module tb_s2p;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rstn;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_clear;
    logic [N-1:0] par_data;
    logic         par_valid;
    logic         par_ready;

    int checks;
    int failures;

    s2p #(.N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_clear (ser_clear),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        ser_valid = 1'b1;
        ser_data  = b;
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
    endtask

    task automatic idle();
        ser_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        ser_data  = 1'b0;
        ser_valid = 1'b0;
        ser_clear = 1'b0;
        par_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_par_valid", par_valid, 0);
        chk("rst_par_data", par_data, 0);
        chk("rst_ser_ready", ser_ready, 1);
        rstn = 1'b1;
        idle();

        // Word 1010, valid exactly on the edge of the 4th bit, one-cycle pulse
        par_ready = 1'b1;
        send(1'b1); chk("t1_b0_valid", par_valid, 0);
        send(1'b0); chk("t1_b1_valid", par_valid, 0);
        send(1'b1); chk("t1_b2_valid", par_valid, 0);
        send(1'b0); chk("t1_valid", par_valid, 1);
        chk("t1_data", par_data, 4'b1010);
        idle();     chk("t1_drained", par_valid, 0);

        // Back-to-back words 1011 then 1110, ser_ready never drops
        send(1'b1); chk("t2_rdy0", ser_ready, 1);
        send(1'b0); chk("t2_rdy1", ser_ready, 1);
        send(1'b1); chk("t2_rdy2", ser_ready, 1);
        send(1'b1); chk("t2_w1_valid", par_valid, 1);
        chk("t2_w1_data", par_data, 4'b1011);
        chk("t2_rdy3", ser_ready, 1);
        send(1'b1); chk("t2_rdy4", ser_ready, 1);
        send(1'b1); chk("t2_rdy5", ser_ready, 1);
        send(1'b1); chk("t2_rdy6", ser_ready, 1);
        send(1'b0); chk("t2_w2_valid", par_valid, 1);
        chk("t2_w2_data", par_data, 4'b1110);
        idle();     chk("t2_drained", par_valid, 0);

        // Backpressure: held word 1111 stalls the last bit of 0001
        par_ready = 1'b0;
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        chk("t3_w1_valid", par_valid, 1);
        chk("t3_w1_data", par_data, 4'b1111);
        send(1'b0); send(1'b0); send(1'b0);
        chk("t3_hold_data", par_data, 4'b1111);
        chk("t3_hold_valid", par_valid, 1);
        ser_valid = 1'b1;
        ser_data  = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_stall_ready", ser_ready, 0);
        chk("t3_stall_data", par_data, 4'b1111);
        par_ready = 1'b1;
        #1;
        chk("t3_drain_ready", ser_ready, 1);
        @(posedge clk);
        #1;
        ser_valid = 1'b0;
        par_ready = 1'b0;
        chk("t3_w2_valid", par_valid, 1);
        chk("t3_w2_data", par_data, 4'b0001);
        idle();
        chk("t3_w2_held", par_data, 4'b0001);
        chk("t3_w2_held_valid", par_valid, 1);
        par_ready = 1'b1;
        idle();     chk("t3_drained", par_valid, 0);

        // ser_clear discards the partial word and its own-cycle beat
        send(1'b0); send(1'b1);
        ser_clear = 1'b1;
        send(1'b1);
        ser_clear = 1'b0;
        chk("t4_clear_valid", par_valid, 0);
        send(1'b0); send(1'b1); send(1'b0);
        chk("t4_partial_valid", par_valid, 0);
        send(1'b0);
        chk("t4_valid", par_valid, 1);
        chk("t4_data", par_data, 4'b0100);
        idle();     chk("t4_drained", par_valid, 0);

        // Gapped input 0,1,1,0
        send(1'b0); idle(); chk("t5_gap0", par_valid, 0);
        idle();     chk("t5_gap1", par_valid, 0);
        send(1'b1); idle(); chk("t5_gap2", par_valid, 0);
        send(1'b1); idle(); chk("t5_gap3", par_valid, 0);
        send(1'b0);
        chk("t5_valid", par_valid, 1);
        chk("t5_data", par_data, 4'b0110);
        idle();     chk("t5_drained", par_valid, 0);

        // Async reset with a word pending and a partial word in flight
        par_ready = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("t6_pending", par_valid, 1);
        send(1'b0); send(1'b1);
        rstn = 1'b0;
        #2;
        chk("t6_rst_valid", par_valid, 0);
        chk("t6_rst_data", par_data, 0);
        chk("t6_rst_ready", ser_ready, 1);
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        par_ready = 1'b1;
        send(1'b0); send(1'b0); send(1'b1);
        chk("t6_partial_valid", par_valid, 0);
        send(1'b1);
        chk("t6_valid", par_valid, 1);
        chk("t6_data", par_data, 4'b0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
